jv1_sector_bridge: RTL

Translates single-sector requests from the TRS-80 floppy controller (drive, track, sector in JV1 geometry) into 512-byte block transfers on the hps_io SD interface. It owns a 512-byte block buffer shared between the SD side and the controller's byte port. Sits between hps_io (sd_*, img_*) and the trs80 core's disk controller. Per-drive mount, read-only and size state is latched here.

---
 rtl/trs80_disk_pkg.sv | 20 ++
 rtl/sector_dpram.sv | 29 ++
 rtl/jv1_sector_bridge.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/trs80_disk_pkg.sv
// Shared geometry constants, error codes and FSM state encoding for the JV1 sector bridge.
package trs80_disk_pkg;
    localparam int SECT_BYTES   = 256;
    localparam int SD_BLK_BYTES = 512;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_NOMNT = 2'd1;
    localparam logic [1:0] ERR_RNF   = 2'd2;
    localparam logic [1:0] ERR_WP    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_REQ,
        ST_RD_XFER,
        ST_WR_REQ,
        ST_WR_XFER,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sector_dpram.sv
// 512x8 true dual-port block buffer: port A faces the SD side, port B the disk controller.
// Both read ports are registered (1-cycle latency); writes are never stalled.
module sector_dpram
    import trs80_disk_pkg::*;
(
    input  logic       i_clk,
    input  logic [8:0] i_a_addr,
    input  logic [7:0] i_a_din,
    input  logic       i_a_we,
    output logic [7:0] o_a_dout,
    input  logic [8:0] i_b_addr,
    input  logic [7:0] i_b_din,
    input  logic       i_b_we,
    output logic [7:0] o_b_dout
);
    logic [7:0] r_mem [SD_BLK_BYTES];
    logic [7:0] r_a_dout;
    logic [7:0] r_b_dout;

    always_ff @(posedge i_clk) begin
        if (i_a_we) r_mem[i_a_addr] <= i_a_din;
        if (i_b_we) r_mem[i_b_addr] <= i_b_din;
        r_a_dout <= r_mem[i_a_addr];
        r_b_dout <= r_mem[i_b_addr];
    end

    assign o_a_dout = r_a_dout;
    assign o_b_dout = r_b_dout;
endmodule

// File: rtl/jv1_sector_bridge.sv
// Maps JV1 (drive, track, sector) requests onto 512-byte SD block reads/writes via a shared buffer.
// Error completion 3 cycles after request; SD handshake paced entirely by sd_ack; requests while busy are dropped.
module jv1_sector_bridge
    import trs80_disk_pkg::*;
#(
    parameter int NBDRIV       = 4,
    parameter int SECT_PER_TRK = 10
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NBDRIV-1:0] i_img_mounted,
    input  logic              i_img_readonly,
    input  logic [63:0]       i_img_size,
    input  logic              i_req_rd,
    input  logic              i_req_wr,
    input  logic [1:0]        i_drive,
    input  logic [6:0]        i_track,
    input  logic [3:0]        i_sector,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_err,
    input  logic [7:0]        i_buf_addr,
    input  logic [7:0]        i_buf_din,
    input  logic              i_buf_we,
    output logic [7:0]        o_buf_dout,
    output logic [31:0]       o_sd_lba,
    output logic [NBDRIV-1:0] o_sd_rd,
    output logic [NBDRIV-1:0] o_sd_wr,
    input  logic              i_sd_ack,
    input  logic [8:0]        i_sd_buff_addr,
    input  logic [7:0]        i_sd_buff_dout,
    input  logic              i_sd_buff_wr,
    output logic [7:0]        o_sd_buff_din
);
    state_t            r_state;
    state_t            w_next;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_err;
    logic [1:0]        w_err_nxt;
    logic              r_op_wr;
    logic [31:0]       r_lba;
    logic [NBDRIV-1:0] r_sd_rd;
    logic [NBDRIV-1:0] r_sd_wr;
    logic [NBDRIV-1:0] r_mounted;
    logic [NBDRIV-1:0] r_ro;
    logic [31:0]       r_size [NBDRIV];

    logic [10:0]       w_idx;
    logic              w_half;
    logic [31:0]       w_end;
    logic              w_mnt;
    logic              w_ro;
    logic [31:0]       w_size;
    logic [NBDRIV-1:0] w_sel;
    logic              w_a_we;
    logic              w_b_we;

    assign w_idx  = 11'(i_track) * 11'(SECT_PER_TRK) + 11'(i_sector);
    assign w_half = w_idx[0];
    assign w_end  = (32'(w_idx) + 32'd1) * 32'(SECT_BYTES);

    always_comb begin
        w_mnt  = 1'b0;
        w_ro   = 1'b0;
        w_size = '0;
        w_sel  = '0;
        for (int i = 0; i < NBDRIV; i++) begin
            if (int'(i_drive) == i) begin
                w_mnt    = r_mounted[i];
                w_ro     = r_ro[i];
                w_size   = r_size[i];
                w_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_err_nxt = r_err;
        case (r_state)
            ST_IDLE:    if (i_req_rd || i_req_wr) w_next = ST_CHECK;
            ST_CHECK: begin
                w_next = ST_DONE;
                if (!w_mnt)
                    w_err_nxt = ERR_NOMNT;
                else if ({28'd0, i_sector} >= 32'(SECT_PER_TRK) || w_end > w_size)
                    w_err_nxt = ERR_RNF;
                else if (r_op_wr && w_ro)
                    w_err_nxt = ERR_WP;
                else begin
                    w_err_nxt = ERR_OK;
                    w_next    = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  if (i_sd_ack) w_next = ST_RD_XFER;
            ST_RD_XFER: if (!i_sd_ack) w_next = r_op_wr ? ST_WR_REQ : ST_DONE;
            ST_WR_REQ:  if (i_sd_ack) w_next = ST_WR_XFER;
            ST_WR_XFER: if (!i_sd_ack) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= ERR_OK;
            r_op_wr   <= 1'b0;
            r_lba     <= '0;
            r_sd_rd   <= '0;
            r_sd_wr   <= '0;
            r_mounted <= '0;
            r_ro      <= '0;
        end else begin
            r_state <= w_next;
            // busy stays up through DONE so it falls in the same cycle done pulses
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (r_state == ST_DONE);
            r_err   <= w_err_nxt;
            r_sd_rd <= (r_state == ST_RD_REQ && !i_sd_ack) ? w_sel : '0;
            r_sd_wr <= (r_state == ST_WR_REQ && !i_sd_ack) ? w_sel : '0;
            if (r_state == ST_IDLE && (i_req_rd || i_req_wr))
                r_op_wr <= !i_req_rd;
            if (r_state == ST_CHECK)
                r_lba <= {21'd0, w_idx[10:1]};
            for (int i = 0; i < NBDRIV; i++) begin
                if (i_img_mounted[i]) begin
                    r_mounted[i] <= |i_img_size;
                    r_ro[i]      <= i_img_readonly;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        for (int i = 0; i < NBDRIV; i++)
            if (i_img_mounted[i]) r_size[i] <= i_img_size[31:0];
    end

    // On a write op the controller's half must survive the read phase of the read-modify-write
    assign w_a_we = i_sd_buff_wr && (r_state == ST_RD_XFER)
                    && !(r_op_wr && (i_sd_buff_addr[8] == w_half));
    assign w_b_we = i_buf_we && (r_state == ST_IDLE);

    sector_dpram u_buf (
        .i_clk    (i_clock),
        .i_a_addr (i_sd_buff_addr),
        .i_a_din  (i_sd_buff_dout),
        .i_a_we   (w_a_we),
        .o_a_dout (o_sd_buff_din),
        .i_b_addr ({w_half, i_buf_addr}),
        .i_b_din  (i_buf_din),
        .i_b_we   (w_b_we),
        .o_b_dout (o_buf_dout)
    );

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_sd_lba = r_lba;
    assign o_sd_rd  = r_sd_rd;
    assign o_sd_wr  = r_sd_wr;
endmodule
